// File: rtl/sar_adc_mc_pkg.sv
// Shared definitions for the multi-channel SAR ADC controller:
// FSM encodings and constant helpers used to size counters and build the midscale code.
package sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUX  = 2'd1,
        CONV = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Single 1 in the MSB position of a w-bit code; callers truncate to their width.
    function automatic logic [31:0] midscale(input int w);
        return 32'h1 << (w - 1);
    endfunction

endpackage

// File: rtl/sar_adc_mc_if.sv
// Bundles the analog-side controls and the result holding-register handshake of sar_adc_mc.
interface sar_adc_mc_if #(
    parameter int ADC_WIDTH = 8,
    parameter int CH_NUM    = 4,
    parameter int CH_W      = 2
);
    logic                 cmp;
    logic                 start;
    logic                 scan_en;
    logic [CH_NUM-1:0]    ch_mask;
    logic [CH_W-1:0]      mux_sel;
    logic [ADC_WIDTH-1:0] DACF;
    logic                 busy;
    logic                 eoc;
    // Result transfer: a result is consumed on any clock edge where dout_valid & dout_ready;
    // dout/dout_ch stay stable while valid is held, except when a newer result overwrites them.
    logic [ADC_WIDTH-1:0] dout;
    logic [CH_W-1:0]      dout_ch;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 ovr;
    logic [1:0]           dbg_state;

    modport master (
        input  cmp, start, scan_en, ch_mask, dout_ready,
        output mux_sel, DACF, busy, eoc, dout, dout_ch, dout_valid, ovr, dbg_state
    );

    modport slave (
        output cmp, start, scan_en, ch_mask, dout_ready,
        input  mux_sel, DACF, busy, eoc, dout, dout_ch, dout_valid, ovr, dbg_state
    );
endinterface

// File: rtl/sar_adc_mc_rr_pick.sv
// Combinational channel finder: next set mask bit strictly above i_cur, and the lowest set bit.
module sar_rr_pick #(
    parameter int CH_NUM = 4,
    parameter int CH_W   = 2
) (
    input  logic [CH_NUM-1:0] i_mask,
    input  logic [CH_W-1:0]   i_cur,
    output logic [CH_W-1:0]   o_nxt,
    output logic              o_found,
    output logic [CH_W-1:0]   o_lowest
);
    always_comb begin
        o_nxt    = '0;
        o_found  = 1'b0;
        o_lowest = '0;
        // Scanning downward leaves the smallest qualifying index as the final assignment.
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_lowest = CH_W'(i);
                if (i > int'(i_cur)) begin
                    o_found = 1'b1;
                    o_nxt   = CH_W'(i);
                end
            end
        end
    end
endmodule

// File: rtl/sar_adc_mc.sv
// Multi-channel SAR ADC controller: sweeps masked channels through mux settle and
// bit-by-bit binary search, delivering results through a valid/ready holding register.
module sar_adc_mc
    import sar_adc_pkg::*;
#(
    parameter int ADC_WIDTH  = 8,
    parameter int CH_NUM     = 4,
    parameter int CH_W       = 2,
    parameter int SETTLE     = 1,
    parameter int MUX_SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sar_adc_mc_if.master  bus
);
    localparam int CNT_MAX = (SETTLE > MUX_SETTLE) ? SETTLE : MUX_SETTLE;
    localparam int CNT_W   = clog2(CNT_MAX + 1);
    localparam int BIT_W   = clog2(ADC_WIDTH);
    localparam logic [ADC_WIDTH-1:0] MIDSCALE = ADC_WIDTH'(midscale(ADC_WIDTH));

    state_t               r_state, w_state_nxt;
    logic                 r_start;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [BIT_W-1:0]     r_bit, w_bit_nxt;
    logic [CH_NUM-1:0]    r_mask, w_mask_nxt;
    logic [CH_W-1:0]      r_mux_sel, w_mux_nxt;
    logic [ADC_WIDTH-1:0] r_dacf, w_dacf_nxt;
    logic [ADC_WIDTH-1:0] r_dout, w_res;
    logic [CH_W-1:0]      r_dout_ch;
    logic                 r_valid, r_eoc, r_ovr, w_eoc_nxt, w_res_wr;
    logic                 w_start_e, w_first_any, w_nxt_found;
    logic [CH_W-1:0]      w_nxt_ch, w_first_ch, w_unused_lowest, w_unused_nxt;
    logic                 w_unused_found;

    assign w_start_e   = bus.start & ~r_start;
    assign w_first_any = |bus.ch_mask;

    sar_rr_pick #(.CH_NUM(CH_NUM), .CH_W(CH_W)) u_pick_next (
        .i_mask(r_mask), .i_cur(r_mux_sel),
        .o_nxt(w_nxt_ch), .o_found(w_nxt_found), .o_lowest(w_unused_lowest)
    );

    sar_rr_pick #(.CH_NUM(CH_NUM), .CH_W(CH_W)) u_pick_first (
        .i_mask(bus.ch_mask), .i_cur('0),
        .o_nxt(w_unused_nxt), .o_found(w_unused_found), .o_lowest(w_first_ch)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_mask_nxt  = r_mask;
        w_mux_nxt   = r_mux_sel;
        w_dacf_nxt  = r_dacf;
        w_eoc_nxt   = 1'b0;
        w_res_wr    = 1'b0;
        w_res       = {r_dacf[ADC_WIDTH-1:1], bus.cmp};
        case (r_state)
            IDLE: begin
                w_dacf_nxt = MIDSCALE;
                if (w_start_e && w_first_any) begin
                    w_mask_nxt  = bus.ch_mask;
                    w_mux_nxt   = w_first_ch;
                    w_cnt_nxt   = '0;
                    w_state_nxt = MUX;
                end
            end
            MUX: begin
                w_dacf_nxt = MIDSCALE;
                if (r_cnt == CNT_W'(MUX_SETTLE - 1)) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = BIT_W'(ADC_WIDTH - 1);
                    w_state_nxt = CONV;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            CONV: begin
                if (r_cnt != CNT_W'(SETTLE - 1)) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else if (r_bit != '0) begin
                    w_cnt_nxt                       = '0;
                    w_dacf_nxt[r_bit]               = bus.cmp;
                    w_dacf_nxt[r_bit - BIT_W'(1)]   = 1'b1;
                    w_bit_nxt                       = r_bit - BIT_W'(1);
                end else begin
                    // Last bit decided: store the result and pick what follows it.
                    w_cnt_nxt  = '0;
                    w_res_wr   = 1'b1;
                    w_dacf_nxt = MIDSCALE;
                    if (w_nxt_found) begin
                        w_mux_nxt   = w_nxt_ch;
                        w_state_nxt = MUX;
                    end else begin
                        w_eoc_nxt = 1'b1;
                        if (bus.scan_en && w_first_any) begin
                            w_mask_nxt  = bus.ch_mask;
                            w_mux_nxt   = w_first_ch;
                            w_state_nxt = MUX;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_start   <= 1'b0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_mask    <= '0;
            r_mux_sel <= '0;
            r_dacf    <= '0;
            r_eoc     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start   <= bus.start;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_mask    <= w_mask_nxt;
            r_mux_sel <= w_mux_nxt;
            r_dacf    <= w_dacf_nxt;
            r_eoc     <= w_eoc_nxt;
        end
    end

    // A fresh result always wins over a same-cycle handshake; only an unread result counts as overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout    <= '0;
            r_dout_ch <= '0;
            r_valid   <= 1'b0;
            r_ovr     <= 1'b0;
        end else if (w_res_wr) begin
            r_dout    <= w_res;
            r_dout_ch <= r_mux_sel;
            r_valid   <= 1'b1;
            r_ovr     <= r_valid & ~bus.dout_ready;
        end else begin
            r_ovr <= 1'b0;
            if (r_valid && bus.dout_ready) r_valid <= 1'b0;
        end
    end

    assign bus.mux_sel    = r_mux_sel;
    assign bus.DACF       = r_dacf;
    assign bus.busy       = (r_state != IDLE);
    assign bus.eoc        = r_eoc;
    assign bus.dout       = r_dout;
    assign bus.dout_ch    = r_dout_ch;
    assign bus.dout_valid = r_valid;
    assign bus.ovr        = r_ovr;
    assign bus.dbg_state  = r_state;
endmodule

// File: doc/sar_adc_mc.md
Name: sar_adc_mc

Overview:
Multi-channel successive-approximation ADC controller. It drives an external DAC, an external comparator and an external analog input multiplexer. It sweeps a masked set of channels in single or continuous-scan mode. Per-bit settle time and mux settle time are parameterised, and results leave through a valid/ready holding register with overrun detection. Pure logic, portable to any FPGA, and a drop-in successor to the single-channel SAR controller.

Parameters:
ADC_WIDTH, 8, result/DAC width in bits (2..32).
CH_NUM, 4, number of analog channels (1..16).
CH_W, 2, width of channel index; must satisfy 2^CH_W >= CH_NUM.
SETTLE, 1, cycles per bit phase; cmp is sampled on the last cycle (>=1).
MUX_SETTLE, 2, cycles held in MUX state after a channel switch (>=1).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset, synchronous release
cmp  in  1  comparator: 1 = Vin >= DAC output
start  in  1  sweep start, rising-edge triggered (registered edge detect)
scan_en  in  1  1 = restart sweep automatically after the last channel
ch_mask  in  CH_NUM  enabled channels, latched at sweep start
mux_sel  out  CH_W  analog mux channel select
DACF  out  ADC_WIDTH  DAC trial code
busy  out  1  high in any state except IDLE
eoc  out  1  one-cycle pulse at end of each sweep
dout  out  ADC_WIDTH  result
dout_ch  out  CH_W  channel of dout
dout_valid  out  1  result held
dout_ready  in  1  consumer accepts when valid & ready
ovr  out  1  one-cycle pulse when an unread result is overwritten

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous, active-low. On reset, all outputs are 0, the state is IDLE and the start edge register is 0.
- Edge detect: start_e = start & ~start_r.
- States: IDLE, MUX, CONV.
- IDLE:
  - DACF = {1, 0...0} (midscale).
  - On start_e with ch_mask != 0: latch the mask to mask_r, set mux_sel to the lowest set bit, go to MUX.
  - start_e with ch_mask == 0 is ignored.
- MUX:
  - Hold for MUX_SETTLE cycles with DACF = midscale, then go to CONV with bit index = ADC_WIDTH-1.
- CONV:
  - Each bit phase lasts SETTLE cycles.
  - On the last cycle of phase i (i > 0): DACF[i] <= cmp, DACF[i-1] <= 1, i <= i-1.
  - On the last cycle of phase 0: dout <= {DACF[ADC_WIDTH-1:1], cmp}, dout_ch <= mux_sel, dout_valid <= 1.
- After a result is written, the next channel is the next set bit of mask_r above mux_sel.
  - If a next channel exists: update mux_sel, go to MUX.
  - Else if scan_en = 1: eoc pulse, relatch ch_mask (ch_mask == 0 -> IDLE), mux_sel = lowest set bit, go to MUX.
  - Else: eoc pulse, go to IDLE.
- Latency: MUX_SETTLE + ADC_WIDTH*SETTLE cycles per channel, counted from entering MUX to dout_valid rising.
- start_e while busy is ignored.
- scan_en sampled only at sweep end; deasserting it mid-sweep completes the current sweep.
- Output register:
  - dout_valid clears on valid & ready.
  - If a new result lands with valid & ~ready: overwrite dout/dout_ch, keep valid = 1, ovr = 1 for one cycle.
  - If a new result lands in the same cycle as a handshake: the new result wins, valid stays 1, ovr = 0.
- Mask changes after latching have no effect until the next sweep.
- Reset mid-conversion aborts immediately: outputs go to 0, the result is lost.
- Counters:
  - Settle counter width $clog2(max(SETTLE, MUX_SETTLE)+1).
  - Bit index width $clog2(ADC_WIDTH).
  - No wrap beyond the terminal count.

Decomposition:
- Shared package/include sar_adc_pkg:
  - State encodings IDLE = 0, MUX = 1, CONV = 2.
  - Helper constant for midscale code generation.
  - clog2 function.
- One sub-module, sar_rr_pick: combinational next-set-bit finder (mask, current index -> next index, found flag, lowest index). It is instantiated twice: next channel, and first channel.

Test Plan:
- Test configuration: ADC_WIDTH = 8, CH_NUM = 4, SETTLE = 2, MUX_SETTLE = 3; behavioural comparator cmp = (vin[mux_sel] >= DACF).
- Single channel: mask = 4'b0001, vin0 = 0xA5, start pulse -> dout = 0xA5, dout_ch = 0, dout_valid rises 19 cycles after MUX entry, then eoc pulse, return to IDLE, DACF = 0x80.
- Sparse mask: mask = 4'b1010, vin1 = 0x00, vin3 = 0xFF, ready = 1 -> results (ch1, 0x00) then (ch3, 0xFF), one eoc after ch3, mux_sel sequence 1 -> 3.
- Scan mode: scan_en = 1, mask = 4'b0011, vin = {0x12, 0x34}, ready = 1 -> repeating 0x12, 0x34; eoc after each pair; scan_en dropped mid-sweep -> sweep completes, then IDLE.
- Overrun: ready = 0, mask = 4'b0011 -> second result overwrites the first, ovr one-cycle pulse, dout_valid stays 1. A result coinciding with a ready handshake -> ovr = 0.
- Edge cases:
  - start held high -> single sweep only.
  - start_e while busy -> ignored.
  - mask = 0 -> no activity, busy = 0.
  - rst_n low mid-CONV -> all outputs 0 asynchronously; restart yields a correct result.
